// File: rtl/iq_sample_capture.sv
// iq_sample_capture: pipelined wishbone slave that snapshots the I/Q sample
// stream into on-chip RAM and lets the host read the words back.
// Register page: 0 CTRL/STATUS, 1 DECIM, 2 RDPTR, 3 DATA.
// Optional feature macro: CAPTURE_TRIGGER_EN builds the ARMED state and the
// rising zero-crossing detector on I; without it ARM starts capture at once.
module iq_sample_capture #(
  parameter int sample_width = 16,
  parameter int lg_depth     = 10
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_wb_cyc,
  input  logic                    i_wb_stb,
  input  logic                    i_wb_we,
  input  logic [1:0]              i_wb_addr,
  input  logic [31:0]             i_wb_data,
  output logic                    o_wb_ack,
  output logic                    o_wb_stall,
  output logic [31:0]             o_wb_data,
  input  logic [sample_width-1:0] i_sample_i,
  input  logic [sample_width-1:0] i_sample_q
);

  localparam int DEPTH = 1 << lg_depth;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [lg_depth-1:0] wptr;
  logic [lg_depth-1:0] rptr;
  logic [lg_depth:0]   count;
  logic [15:0]         decim;
  logic [15:0]         dcnt;
  logic                store;
  logic                last;
  logic [31:0]         ram_q;
  logic [31:0]         reg_q;
  logic                data_from_ram;
  logic [31:0]         mem [DEPTH];

  // Bus decode; every accepted strobe gets exactly one ack next clock.
  logic accept, bus_rd, bus_wr, ctrl_wr, abort, arm;
  assign accept  = i_wb_cyc & i_wb_stb;
  assign bus_rd  = accept & ~i_wb_we;
  assign bus_wr  = accept & i_wb_we;
  assign ctrl_wr = bus_wr && (i_wb_addr == 2'd0);
  assign abort   = ctrl_wr & i_wb_data[1];
  assign arm     = ctrl_wr & i_wb_data[0] & ~i_wb_data[1];

  assign o_wb_stall = 1'b0;
  assign last       = (count == (lg_depth+1)'(DEPTH - 1));

  // Upper write-data bits have no register behind them.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, i_wb_data[31:16]};

  // Samples are stored as two sign-extended 16-bit halves, I on top.
  logic [15:0] i16, q16;
  assign i16 = 16'($signed(i_sample_i));
  assign q16 = 16'($signed(i_sample_q));

`ifdef CAPTURE_TRIGGER_EN
  // Rising zero crossing: previous I negative, current I non-negative.
  logic [sample_width-1:0] prev_i;
  logic                    trig;
  assign trig = prev_i[sample_width-1] & ~i_sample_i[sample_width-1];

  // Previous-sample register for the crossing detector.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) prev_i <= '0;
    else         prev_i <= i_sample_i;
  end
`endif

  // Capture state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_n;
  end

  // Next state and store decision; ABORT beats ARM, both beat capture.
  always_comb begin
    state_n = state;
    store   = 1'b0;
    if (abort) begin
      state_n = S_IDLE;
    end else if (arm) begin
`ifdef CAPTURE_TRIGGER_EN
      state_n = S_ARMED;
`else
      state_n = S_CAPTURE;
`endif
    end else begin
      case (state)
`ifdef CAPTURE_TRIGGER_EN
        S_ARMED: begin
          // The triggering sample is the first one stored.
          if (trig) begin
            store   = 1'b1;
            state_n = last ? S_DONE : S_CAPTURE;
          end
        end
`endif
        S_CAPTURE: begin
          if (dcnt == 16'd0) begin
            store = 1'b1;
            if (last) state_n = S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Write pointer, saturating count and decimation counter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wptr  <= '0;
      count <= '0;
      dcnt  <= '0;
    end else if (arm) begin
      wptr  <= '0;
      count <= '0;
      dcnt  <= '0;
    end else if (store) begin
      wptr  <= wptr + 1'b1;
      count <= count + 1'b1;
      dcnt  <= decim;
    end else if (state == S_CAPTURE && dcnt != 16'd0 && !abort) begin
      dcnt  <= dcnt - 16'd1;
    end
  end

  // Capture RAM write port; contents are not reset.
  always_ff @(posedge i_clk) begin
    if (store) mem[wptr] <= {i16, q16};
  end

  // Synchronous RAM read at the current read pointer.
  always_ff @(posedge i_clk) begin
    ram_q <= mem[rptr];
  end

  // Register file, ack and read-data staging.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_wb_ack      <= 1'b0;
      reg_q         <= '0;
      data_from_ram <= 1'b0;
      decim         <= '0;
      rptr          <= '0;
    end else begin
      o_wb_ack      <= accept;
      reg_q         <= '0;
      data_from_ram <= 1'b0;
      if (bus_rd) begin
        case (i_wb_addr)
          2'd0: reg_q <= {16'(count), 14'd0, state};
          2'd1: reg_q <= {16'd0, decim};
          2'd2: reg_q <= 32'(rptr);
          default: begin
            data_from_ram <= 1'b1;
            rptr          <= rptr + 1'b1;
          end
        endcase
      end
      if (bus_wr) begin
        case (i_wb_addr)
          2'd1:    decim <= i_wb_data[15:0];
          2'd2:    rptr  <= i_wb_data[lg_depth-1:0];
          default: ;
        endcase
      end
    end
  end

  assign o_wb_data = data_from_ram ? ram_q : reg_q;

endmodule
